// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_e;

   localparam int MEM_DATA_W = 32;
   localparam int MEM_BE_W   = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one synchronous-read memory: combinational grant, read data one cycle later.
// Data wins unless a fetch has waited MAX_DM_RUN data grants; the loser holds its request (fetch sees stall_o).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int MAX_DM_RUN = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_req_i,
   input  logic [ADDR_W-1:0]       if_addr_i,
   output logic                    if_gnt_o,
   output logic                    if_rvalid_o,
   output logic [MEM_DATA_W-1:0]   if_rdata_o,
   input  logic                    if_flush_i,
   input  logic                    dm_req_i,
   input  logic                    dm_we_i,
   input  logic [ADDR_W-1:0]       dm_addr_i,
   input  logic [MEM_BE_W-1:0]     dm_be_i,
   input  logic [MEM_DATA_W-1:0]   dm_wdata_i,
   output logic                    dm_gnt_o,
   output logic                    dm_rvalid_o,
   output logic [MEM_DATA_W-1:0]   dm_rdata_o,
   output logic                    stall_o,
   output logic                    mem_en_o,
   output logic                    mem_we_o,
   output logic [MEM_BE_W-1:0]     mem_be_o,
   output logic [ADDR_W-3:0]       mem_addr_o,
   output logic [MEM_DATA_W-1:0]   mem_wdata_o,
   input  logic [MEM_DATA_W-1:0]   mem_rdata_i
);

   localparam logic [3:0] RUN_MAX = 4'(MAX_DM_RUN);

   logic [3:0] run_cnt_q, run_cnt_d;
   owner_e     owner_q, owner_d;
   logic       fetch_wins;

   // Byte offsets are dropped on the word-addressed memory side.
   logic       unused_addr_lsbs;
   assign unused_addr_lsbs = ^{if_addr_i[1:0], dm_addr_i[1:0]};

   always_comb begin
      fetch_wins  = if_req_i && (run_cnt_q == RUN_MAX);
      dm_gnt_o    = rst && dm_req_i && !fetch_wins;
      if_gnt_o    = rst && if_req_i && !dm_gnt_o;
      stall_o     = rst && if_req_i && !if_gnt_o;

      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (dm_gnt_o) begin
         mem_en_o    = 1'b1;
         mem_we_o    = dm_we_i;
         mem_be_o    = dm_we_i ? dm_be_i : 4'hF;
         mem_addr_o  = dm_addr_i[ADDR_W-1:2];
         mem_wdata_o = dm_we_i ? dm_wdata_i : '0;
      end else if (if_gnt_o) begin
         mem_en_o    = 1'b1;
         mem_be_o    = 4'hF;
         mem_addr_o  = if_addr_i[ADDR_W-1:2];
      end

      // A waiting fetch is what the run counter measures; no waiting fetch, no run.
      run_cnt_d = run_cnt_q;
      if (!if_req_i || if_gnt_o) begin
         run_cnt_d = '0;
      end else if (dm_gnt_o && (run_cnt_q < RUN_MAX)) begin
         run_cnt_d = run_cnt_q + 4'd1;
      end

      owner_d = OWN_NONE;
      if (if_gnt_o) begin
         owner_d = OWN_IF;
      end else if (dm_gnt_o && !dm_we_i) begin
         owner_d = OWN_DM;
      end

      // Flush kills only the response already in flight, not a grant made this cycle.
      if_rvalid_o = (owner_q == OWN_IF) && !if_flush_i;
      dm_rvalid_o = (owner_q == OWN_DM);
      if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
      dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_cnt_q <= '0;
         owner_q   <= OWN_NONE;
      end else begin
         run_cnt_q <= run_cnt_d;
         owner_q   <= owner_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural memory behind the mem_* port.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req_i;
   logic [9:0]  if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        if_flush_i;
   logic        dm_req_i;
   logic        dm_we_i;
   logic [9:0]  dm_addr_i;
   logic [3:0]  dm_be_i;
   logic [31:0] dm_wdata_i;
   logic        dm_gnt_o;
   logic        dm_rvalid_o;
   logic [31:0] dm_rdata_o;
   logic        stall_o;
   logic        mem_en_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [7:0]  mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;

   int checks;
   int errors;

   logic [31:0] mem [256];

   mem_port_arbiter #(.ADDR_W(10), .MAX_DM_RUN(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_gnt_o    (if_gnt_o),
      .if_rvalid_o (if_rvalid_o),
      .if_rdata_o  (if_rdata_o),
      .if_flush_i  (if_flush_i),
      .dm_req_i    (dm_req_i),
      .dm_we_i     (dm_we_i),
      .dm_addr_i   (dm_addr_i),
      .dm_be_i     (dm_be_i),
      .dm_wdata_i  (dm_wdata_i),
      .dm_gnt_o    (dm_gnt_o),
      .dm_rvalid_o (dm_rvalid_o),
      .dm_rdata_o  (dm_rdata_o),
      .stall_o     (stall_o),
      .mem_en_o    (mem_en_o),
      .mem_we_o    (mem_we_o),
      .mem_be_o    (mem_be_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory; word i starts as 0xA5000000 | i.
   always @(posedge clk) begin
      if (mem_en_o) begin
         if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
         end else begin
            mem_rdata_i <= mem[mem_addr_o];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_req_i   = 1'b0;
      dm_req_i   = 1'b0;
      dm_we_i    = 1'b0;
      if_flush_i = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
      mem_rdata_i = '0;
      rst        = 1'b0;
      if_req_i   = 1'b1;
      if_addr_i  = 10'h004;
      if_flush_i = 1'b0;
      dm_req_i   = 1'b1;
      dm_we_i    = 1'b0;
      dm_addr_i  = 10'h008;
      dm_be_i    = 4'hF;
      dm_wdata_i = 32'h1234_5678;

      // Reset with both requests high: everything must be quiet.
      #3;
      chk("rst_if_gnt", 32'(if_gnt_o), 0);
      chk("rst_dm_gnt", 32'(dm_gnt_o), 0);
      chk("rst_stall",  32'(stall_o), 0);
      chk("rst_mem_en", 32'(mem_en_o), 0);
      chk("rst_mem_addr", 32'(mem_addr_o), 0);
      chk("rst_mem_be", 32'(mem_be_o), 0);
      idle();
      next_cycle();
      rst = 1'b1;
      next_cycle();

      // Fetch only, back to back.
      if_req_i = 1'b1; if_addr_i = 10'h000;
      @(negedge clk);
      chk("f0_gnt", 32'(if_gnt_o), 1);
      chk("f0_addr", 32'(mem_addr_o), 32'h000);
      chk("f0_be", 32'(mem_be_o), 32'hF);
      chk("f0_stall", 32'(stall_o), 0);
      next_cycle();
      if_addr_i = 10'h004;
      @(negedge clk);
      chk("f1_addr", 32'(mem_addr_o), 32'h001);
      chk("f1_rvalid", 32'(if_rvalid_o), 1);
      chk("f1_rdata", if_rdata_o, 32'hA500_0000);
      chk("f1_stall", 32'(stall_o), 0);
      next_cycle();
      idle();
      @(negedge clk);
      chk("f2_rvalid", 32'(if_rvalid_o), 1);
      chk("f2_rdata", if_rdata_o, 32'hA500_0001);
      chk("f2_mem_en", 32'(mem_en_o), 0);
      next_cycle();

      // Simultaneous fetch and load.
      if_req_i = 1'b1; if_addr_i = 10'h008;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 10'h040;
      @(negedge clk);
      chk("sim_dm_gnt", 32'(dm_gnt_o), 1);
      chk("sim_if_gnt", 32'(if_gnt_o), 0);
      chk("sim_stall", 32'(stall_o), 1);
      chk("sim_addr", 32'(mem_addr_o), 32'h010);
      next_cycle();
      dm_req_i = 1'b0;
      @(negedge clk);
      chk("sim_dm_rvalid", 32'(dm_rvalid_o), 1);
      chk("sim_dm_rdata", dm_rdata_o, 32'hA500_0010);
      chk("sim_if_gnt2", 32'(if_gnt_o), 1);
      chk("sim_if_rvalid_none", 32'(if_rvalid_o), 0);
      next_cycle();
      idle();
      @(negedge clk);
      chk("sim_if_rdata", if_rdata_o, 32'hA500_0002);
      next_cycle();

      // Both requesting continuously: D,D,D,D,I repeating.
      if_req_i = 1'b1; if_addr_i = 10'h000;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 10'h000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("run_gnt_%0d", i), {30'd0, dm_gnt_o, if_gnt_o},
             ((i % 5) == 4) ? 32'b01 : 32'b10);
         next_cycle();
      end
      idle();
      next_cycle();

      // Partial store, then read it back.
      dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 10'h080;
      dm_be_i = 4'b0011; dm_wdata_i = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("st_gnt", 32'(dm_gnt_o), 1);
      chk("st_we", 32'(mem_we_o), 1);
      chk("st_be", 32'(mem_be_o), 32'h3);
      chk("st_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      chk("st_addr", 32'(mem_addr_o), 32'h020);
      next_cycle();
      dm_we_i = 1'b0;
      @(negedge clk);
      chk("st_no_rvalid", 32'(dm_rvalid_o), 0);
      chk("st_no_if_rvalid", 32'(if_rvalid_o), 0);
      chk("ld_be", 32'(mem_be_o), 32'hF);
      next_cycle();
      idle();
      @(negedge clk);
      chk("ld_rdata", dm_rdata_o, 32'hA500_BEEF);
      next_cycle();

      // Flush drops the in-flight fetch but not the one granted alongside it.
      if_req_i = 1'b1; if_addr_i = 10'h00C;
      @(negedge clk);
      chk("fl_gnt0", 32'(if_gnt_o), 1);
      next_cycle();
      if_flush_i = 1'b1; if_addr_i = 10'h010;
      @(negedge clk);
      chk("fl_rvalid", 32'(if_rvalid_o), 0);
      chk("fl_rdata", if_rdata_o, 0);
      chk("fl_gnt1", 32'(if_gnt_o), 1);
      chk("fl_addr", 32'(mem_addr_o), 32'h004);
      next_cycle();
      idle();
      @(negedge clk);
      chk("fl_new_rvalid", 32'(if_rvalid_o), 1);
      chk("fl_new_rdata", if_rdata_o, 32'hA500_0004);
      next_cycle();

      // Reset mid-cycle with a load in flight and run_cnt at 2.
      if_req_i = 1'b1; dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 10'h014;
      next_cycle();
      next_cycle();
      #1;
      rst = 1'b0;
      #1;
      chk("mrst_dm_rvalid", 32'(dm_rvalid_o), 0);
      chk("mrst_dm_rdata", dm_rdata_o, 0);
      chk("mrst_gnts", {30'd0, dm_gnt_o, if_gnt_o}, 0);
      chk("mrst_mem_en", 32'(mem_en_o), 0);
      chk("mrst_stall", 32'(stall_o), 0);
      idle();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      next_cycle();
      @(negedge clk);
      chk("post_rst_dm_rvalid", 32'(dm_rvalid_o), 0);
      next_cycle();
      // A cleared run counter gives four data grants before the fetch.
      if_req_i = 1'b1; dm_req_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst_gnt_%0d", i), {30'd0, dm_gnt_o, if_gnt_o},
             (i == 4) ? 32'b01 : 32'b10);
         next_cycle();
      end
      idle();
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-ported, synchronous-read unified memory between the pipeline's instruction-fetch port and its data (load/store) port. Each cycle it grants at most one access and routes the one-cycle-late read data back to whichever port issued the read. It also raises a fetch stall toward the PC/IF-ID registers. It sits between the pipeline (fetch in IF, load/store in MEM) and the memory macro.

## Interface
Parameters:
- ADDR_W, 10, byte-address width of both request ports
- MAX_DM_RUN, 4, consecutive data grants allowed while a fetch waits (range 1–15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; held until granted
- if_addr_i  in  ADDR_W  fetch byte address (word-aligned)
- if_gnt_o  out  1  fetch granted this cycle
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  32  fetch read data
- if_flush_i  in  1  discard any in-flight fetch response (taken branch/jump)
- dm_req_i  in  1  data request; held until granted
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  ADDR_W  data byte address
- dm_be_i  in  4  store byte enables
- dm_wdata_i  in  32  store data
- dm_gnt_o  out  1  data granted this cycle
- dm_rvalid_o  out  1  load data valid
- dm_rdata_o  out  32  load data
- stall_o  out  1  = if_req_i & ~if_gnt_o
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write
- mem_be_o  out  4  memory byte enables (4'hF on reads)
- mem_addr_o  out  ADDR_W-2  word address = selected addr[ADDR_W-1:2]
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data, valid the cycle after a read strobe

## Operation
- Grants are combinational in the request cycle. mem_* reflects the granted port in the same cycle. When no port is granted: mem_en_o=0, mem_we_o=0, other mem_* outputs are 0.
- Priority: data wins by default. Fetch wins when run_cnt == MAX_DM_RUN and if_req_i=1.
- run_cnt (4 bit):
  - increments on a data grant while if_req_i=1
  - clears on a fetch grant or whenever if_req_i=0
  - saturates at MAX_DM_RUN
- Response FSM (owner register) has three states: NONE, IF, DM.
  - On a read grant: next state is IF or DM.
  - On a store grant or no grant: next state is NONE.
- Response routing:
  - State IF: if_rvalid_o=1, if_rdata_o=mem_rdata_i.
  - State DM: dm_rvalid_o=1, dm_rdata_o=mem_rdata_i.
  - Rdata outputs are 0 when not valid.
- Flush: if_flush_i=1 while state=IF forces if_rvalid_o=0 that cycle. if_flush_i has no effect on a grant made in the same cycle.
- Stores produce no rvalid.
- Address alignment and byte-enable legality are not checked; both pass through unchanged.

## Timing
- Reset (rst=0, asynchronous): state=NONE, run_cnt=0. All outputs 0 while asserted.
- Any in-flight response is dropped on reset and no rvalid follows after release.
- Read latency: grant in cycle n, rvalid in cycle n+1.
- Back-to-back grants are allowed every cycle. The response for n and the grant for n+1 coexist.
- Simultaneous requests:
  - run_cnt < MAX_DM_RUN: dm granted, stall_o=1.
  - run_cnt == MAX_DM_RUN: if granted, dm_gnt_o=0. The data requester must hold its request.
- With MAX_DM_RUN=4 and both ports requesting continuously, grants follow the repeating pattern D,D,D,D,I.
- Requests dropped before grant are legal and leave no state behind, except run_cnt clearing when if_req_i drops.

## Structure
- Shared package mem_arb_pkg holds:
  - owner enum OWN_NONE/OWN_IF/OWN_DM
  - constant MEM_DATA_W=32
  - constant MEM_BE_W=4
- Single module. No sub-module is warranted: the grant logic and the owner FSM are tightly coupled.

## Test plan
- Fetch only, addrs 0x000, 0x004 back-to-back → mem_addr_o 0x000 then 0x001; if_rvalid_o in the following cycles carries mem_rdata_i; stall_o=0 throughout.
- Simultaneous if_req and dm load at addr 0x040 → dm_gnt_o=1, stall_o=1; next cycle dm_rvalid_o=1 and fetch granted.
- Both requesting continuously for 10 cycles, MAX_DM_RUN=4 → grant sequence D,D,D,D,I,D,D,D,D,I; no fetch starvation.
- Store with dm_be_i=4'b0011, data 0xDEADBEEF → mem_we_o=1, mem_be_o=4'b0011, mem_wdata_o=0xDEADBEEF; no rvalid next cycle.
- Fetch granted, if_flush_i=1 in the next cycle → if_rvalid_o stays 0; a new fetch granted in that same cycle returns rvalid normally one cycle later.
- rst=0 asserted mid-cycle with a load in flight → all outputs 0 immediately; after release no dm_rvalid_o appears and run_cnt=0.
